// File: rtl/max_pool_2x2_serial.sv
// 2x2 stride-1 max pooling over a raster-order MAP_W x MAP_W stream.
// A single-row line buffer lets pooled results stream out while the map is still arriving.
module max_pool_2x2_serial #(
    parameter int MAP_W = 5,
    parameter int DW    = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] In_OFM,
    output logic          out_valid,
    output logic [DW-1:0] Out_POOL,
    output logic          out_last
);

    localparam int CW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(MAP_W - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [DW-1:0] line_buf_q [MAP_W];
    logic [DW-1:0] line_buf_d [MAP_W];
    logic [DW-1:0] prev_q, prev_d;
    logic [DW-1:0] diag_q, diag_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_pool_q, out_pool_d;
    logic          out_last_q, out_last_d;

    logic [DW-1:0] above;
    logic [DW-1:0] max_top;
    logic [DW-1:0] max_bot;
    logic [DW-1:0] max_all;
    logic          at_end;

    always_comb begin
        // line_buf[c-1] already holds the current row by the time column c arrives,
        // so the upper-left sample is kept in diag_q as the "above" of the previous column.
        above   = line_buf_q[col_q];
        max_top = (diag_q > above) ? diag_q : above;
        max_bot = (prev_q > In_OFM) ? prev_q : In_OFM;
        max_all = (max_top > max_bot) ? max_top : max_bot;
        at_end  = (row_q == LAST_IDX) && (col_q == LAST_IDX);

        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        line_buf_d  = line_buf_q;
        prev_d      = prev_q;
        diag_d      = diag_q;
        out_valid_d = 1'b0;
        out_pool_d  = '0;
        out_last_d  = 1'b0;

        if (in_valid) begin
            line_buf_d[col_q] = In_OFM;
            prev_d            = In_OFM;
            diag_d            = above;

            if ((row_q != '0) && (col_q != '0)) begin
                out_valid_d = 1'b1;
                out_pool_d  = max_all;
            end
            out_last_d = at_end;

            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            state_d = at_end ? IDLE : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            for (int unsigned i = 0; i < MAP_W; i++) begin
                line_buf_q[i] <= '0;
            end
            prev_q      <= '0;
            diag_q      <= '0;
            out_valid_q <= 1'b0;
            out_pool_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            line_buf_q  <= line_buf_d;
            prev_q      <= prev_d;
            diag_q      <= diag_d;
            out_valid_q <= out_valid_d;
            out_pool_q  <= out_pool_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Out_POOL  = out_pool_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_max_pool_2x2_serial.sv
// Scoreboard bench for max_pool_2x2_serial: the driver queues hand-computed results,
// the monitor checks value, out_last and exact output cycle.
module tb_max_pool_2x2_serial;

    localparam int MAP_W = 5;
    localparam int DW    = 25;

    typedef logic [DW-1:0] frame_t [25];
    typedef logic [DW-1:0] pool_t  [16];
    typedef struct {
        logic [DW-1:0] val;
        logic          last;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] In_OFM;
    logic          out_valid;
    logic [DW-1:0] Out_POOL;
    logic          out_last;

    int   cyc;
    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    max_pool_2x2_serial #(
        .MAP_W(MAP_W),
        .DW   (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .In_OFM   (In_OFM),
        .out_valid(out_valid),
        .Out_POOL (Out_POOL),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out cyc=%0d got=%h last=%b expected no output", cyc, Out_POOL, out_last);
            end else begin
                e = exp_q.pop_front();
                if (Out_POOL !== e.val || out_last !== e.last || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL pool_out got=%h last=%b cyc=%0d expected=%h last=%b cyc=%0d",
                             Out_POOL, out_last, cyc, e.val, e.last, e.cyc);
                end
            end
        end else begin
            vectors++;
            if (out_valid !== 1'b0 || Out_POOL !== '0 || out_last !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_out cyc=%0d got valid=%b pool=%h last=%b expected 0/0/0",
                         cyc, out_valid, Out_POOL, out_last);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                miscompares++;
                $display("FAIL missing_out cyc=%0d got none expected=%h at cyc=%0d", cyc, e.val, e.cyc);
            end
        end
    end

    task automatic send_frame(input frame_t s, input pool_t e, input bit gap, input int stop_after);
        int k = 0;
        for (int i = 0; i < 25 && i < stop_after; i++) begin
            in_valid = 1'b1;
            In_OFM   = s[i];
            @(posedge clk);
            #1;
            if ((i / MAP_W) >= 1 && (i % MAP_W) >= 1) begin
                exp_q.push_back('{val: e[k], last: (i == 24), cyc: cyc});
                k++;
            end
            in_valid = 1'b0;
            In_OFM   = '0;
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    frame_t ramp, rramp, spike, ramp100, zeros;
    pool_t  exp_ramp, exp_rramp, exp_spike, exp_ramp100;

    initial begin
        exp_ramp  = '{6, 7, 8, 9, 11, 12, 13, 14, 16, 17, 18, 19, 21, 22, 23, 24};
        exp_rramp = '{24, 23, 22, 21, 19, 18, 17, 16, 14, 13, 12, 11, 9, 8, 7, 6};
        exp_spike = '{0, 0, 0, 0, 0, 25'h1FFFFFF, 25'h1FFFFFF, 0,
                      0, 25'h1FFFFFF, 25'h1FFFFFF, 0, 0, 0, 0, 0};
        exp_ramp100 = '{106, 107, 108, 109, 111, 112, 113, 114,
                        116, 117, 118, 119, 121, 122, 123, 124};
        for (int i = 0; i < 25; i++) begin
            ramp[i]    = DW'(i);
            rramp[i]   = DW'(24 - i);
            ramp100[i] = DW'(i + 100);
            spike[i]   = '0;
            zeros[i]   = '0;
        end
        spike[12] = 25'h1FFFFFF;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        In_OFM      = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        idle_cycles(2);

        send_frame(ramp, exp_ramp, 1'b0, 25);
        idle_cycles(3);
        send_frame(rramp, exp_rramp, 1'b0, 25);
        idle_cycles(2);
        send_frame(spike, exp_spike, 1'b0, 25);
        idle_cycles(2);
        send_frame(ramp, exp_ramp, 1'b1, 25);
        idle_cycles(2);
        send_frame(ramp, exp_ramp, 1'b0, 25);
        send_frame(ramp100, exp_ramp100, 1'b0, 25);
        idle_cycles(2);

        // Abort mid-frame; the output from sample 11 is pending and must vanish at once.
        send_frame(ramp, exp_ramp, 1'b0, 12);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        idle_cycles(1);
        send_frame(ramp, exp_ramp, 1'b0, 25);
        idle_cycles(4);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got=%0d outstanding expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
